if_fsm: RTL

IF_FSM -- requirements
Module: if_fsm

---
 rtl/if_fsm.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/if_fsm.sv
// ---------------------------------------------------------------------------
// if_fsm -- instruction fetch sequencer for a 6502-style execute stage.
//
// On if_start (accepted only in IDLE) the block latches pc_next and fetches
// the opcode byte and then the operand/pointer bytes that the addressing
// mode needs. It presents the opcode, effective address and the address of
// the following instruction with if_ready. Every byte read takes three
// edges: ISSUE (address + strobe), WAIT (strobe drop), CAPTURE (data in).
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-low reset
//   if_start       one-cycle fetch request, fetch address on pc_next
//   pc_next        fetch address from execute stage
//   x, y           index registers from execute stage
//   mem_addr       read address (holds its last value between reads)
//   mem_read_en    one-cycle read strobe per byte
//   mem_data_in    read data, valid two edges after the strobe edge
//   opcode         fetched opcode; also feeds the external decoder
//   addr_mode      addressing mode from the decoder (combinational on opcode)
//   if_addr_out    effective address, immediate value or branch target
//   if_pc_next     address of the following instruction
//   immediate_flag if_addr_out[7:0] carries an immediate operand
//   if_ready       outputs valid, instruction presented to execute
// ---------------------------------------------------------------------------
module if_fsm (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_start,
   input  logic [15:0] pc_next,
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   output logic [15:0] mem_addr,
   output logic        mem_read_en,
   input  logic [7:0]  mem_data_in,
   output logic [7:0]  opcode,
   input  logic [3:0]  addr_mode,
   output logic [15:0] if_addr_out,
   output logic [15:0] if_pc_next,
   output logic        immediate_flag,
   output logic        if_ready
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_e;

   typedef enum logic [3:0] {
      M_IMP, M_IMM, M_ZP, M_ZPX, M_ZPY, M_ABS, M_ABSX, M_ABSY,
      M_IND, M_INDX, M_INDY, M_REL
   } mode_e;

   state_e      state_q, state_d;
   logic [2:0]  step_q, step_d;   // index of the byte being read (0 = opcode)
   logic [15:0] pc_q, pc_d;
   // Bytes following the opcode, in read order. Their meaning depends on
   // the mode: INDX/INDY use b2/b3 as lo/hi, IND uses b3/b4 as lo/hi.
   logic [7:0]  b1_q, b1_d, b2_q, b2_d, b3_q, b3_d, b4_q, b4_d;

   logic [15:0] mem_addr_d, if_addr_out_d, if_pc_next_d;
   logic [7:0]  opcode_d;
   logic        mem_read_en_d, immediate_flag_d, if_ready_d;

   mode_e       mode;
   logic [2:0]  nbytes;
   logic [15:0] byte_addr, ea, ilen;
   logic [7:0]  zp_x, zp_y, zp_x_inc, b1_inc;
   logic        finish;

   // Undefined mode codes behave as implied.
   assign mode = (addr_mode > 4'd11) ? M_IMP : mode_e'(addr_mode);

   // Zero-page and in-page arithmetic wraps at 8 bits.
   assign zp_x     = b1_q + x;
   assign zp_y     = b1_q + y;
   assign zp_x_inc = zp_x + 8'd1;
   assign b1_inc   = b1_q + 8'd1;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      nbytes = 3'd2;
      ilen   = 16'd2;
      ea     = 16'h0000;
      case (mode)
         M_IMP:                  begin nbytes = 3'd1; ilen = 16'd1; end
         M_ABS, M_ABSX, M_ABSY:  begin nbytes = 3'd3; ilen = 16'd3; end
         M_IND:                  begin nbytes = 3'd5; ilen = 16'd3; end
         M_INDX, M_INDY:         nbytes = 3'd4;
         default:                ;
      endcase
      case (mode)
         M_IMM, M_ZP: ea = {8'h00, b1_q};
         M_ZPX:       ea = {8'h00, zp_x};
         M_ZPY:       ea = {8'h00, zp_y};
         M_ABS:       ea = {b2_q, b1_q};
         M_ABSX:      ea = {b2_q, b1_q} + {8'h00, x};
         M_ABSY:      ea = {b2_q, b1_q} + {8'h00, y};
         M_IND:       ea = {b4_q, b3_q};
         M_INDX:      ea = {b3_q, b2_q};
         M_INDY:      ea = {b3_q, b2_q} + {8'h00, y};
         M_REL:       ea = pc_q + 16'd2 + {{8{b1_q[7]}}, b1_q};
         default:     ea = 16'h0000;
      endcase
   end

   // Address of operand byte step_q (only used for steps 1..4).
   always_comb begin
      byte_addr = pc_q + 16'd1;
      case (step_q)
         3'd2: begin
            if (mode == M_INDX)      byte_addr = {8'h00, zp_x};
            else if (mode == M_INDY) byte_addr = {8'h00, b1_q};
            else                     byte_addr = pc_q + 16'd2;
         end
         3'd3: begin
            if (mode == M_INDX)      byte_addr = {8'h00, zp_x_inc};
            else if (mode == M_INDY) byte_addr = {8'h00, b1_inc};
            else                     byte_addr = {b2_q, b1_q};
         end
         3'd4:    byte_addr = {b2_q, b1_inc};   // IND hi: page wrap, no carry
         default: byte_addr = pc_q + 16'd1;
      endcase
   end

   // An implied opcode is only known after its capture, so the ISSUE that
   // follows it may find nothing left to read and completes the fetch itself.
   assign finish = (state_q == S_DONE) || (state_q == S_ISSUE && step_q >= nbytes);

   always_comb begin
      state_d          = state_q;
      step_d           = step_q;
      pc_d             = pc_q;
      b1_d             = b1_q;
      b2_d             = b2_q;
      b3_d             = b3_q;
      b4_d             = b4_q;
      mem_addr_d       = mem_addr;
      mem_read_en_d    = 1'b0;
      opcode_d         = opcode;
      if_addr_out_d    = if_addr_out;
      if_pc_next_d     = if_pc_next;
      immediate_flag_d = immediate_flag;
      if_ready_d       = if_ready;

      if (finish) begin
         if_addr_out_d    = ea;
         if_pc_next_d     = pc_q + ilen;
         immediate_flag_d = (mode == M_IMM);
         if_ready_d       = 1'b1;
         step_d           = 3'd0;
         state_d          = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (if_start) begin
                  pc_d          = pc_next;
                  if_ready_d    = 1'b0;
                  mem_addr_d    = pc_next;
                  mem_read_en_d = 1'b1;
                  step_d        = 3'd0;
                  state_d       = S_WAIT;
               end
            end
            S_ISSUE: begin
               mem_addr_d    = byte_addr;
               mem_read_en_d = 1'b1;
               state_d       = S_WAIT;
            end
            S_WAIT: state_d = S_CAPTURE;
            S_CAPTURE: begin
               case (step_q)
                  3'd0:    opcode_d = mem_data_in;
                  3'd1:    b1_d     = mem_data_in;
                  3'd2:    b2_d     = mem_data_in;
                  3'd3:    b3_d     = mem_data_in;
                  default: b4_d     = mem_data_in;
               endcase
               step_d = step_q + 3'd1;
               // The mode is not valid yet while the opcode itself is landing.
               if (step_q != 3'd0 && step_q + 3'd1 == nbytes) state_d = S_DONE;
               else                                           state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (!rst) begin
         // NOTE: the operand byte registers are reset as well so an aborted
         // fetch leaves no stale pointer bytes behind.
         state_q        <= S_IDLE;
         step_q         <= 3'd0;
         pc_q           <= 16'h0000;
         b1_q           <= 8'h00;
         b2_q           <= 8'h00;
         b3_q           <= 8'h00;
         b4_q           <= 8'h00;
         mem_addr       <= 16'h0000;
         mem_read_en    <= 1'b0;
         opcode         <= 8'h00;
         if_addr_out    <= 16'h0000;
         if_pc_next     <= 16'h0000;
         immediate_flag <= 1'b0;
         if_ready       <= 1'b0;
      end else begin
         state_q        <= state_d;
         step_q         <= step_d;
         pc_q           <= pc_d;
         b1_q           <= b1_d;
         b2_q           <= b2_d;
         b3_q           <= b3_d;
         b4_q           <= b4_d;
         mem_addr       <= mem_addr_d;
         mem_read_en    <= mem_read_en_d;
         opcode         <= opcode_d;
         if_addr_out    <= if_addr_out_d;
         if_pc_next     <= if_pc_next_d;
         immediate_flag <= immediate_flag_d;
         if_ready       <= if_ready_d;
      end
   end

endmodule
